// File: rtl/wm8731_i2c_config_if.sv
// ============================================================================
// Interface : wm8731_i2c_config_if
// Purpose   : Control/status and I2C pin bundle of the WM8731 config sequencer.
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface wm8731_i2c_config_if;
    logic       start;
    logic       i2c_sclk;
    logic       i2c_sdat_in;
    logic       i2c_sdat_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] entry_idx;

    modport master (
        input  start, i2c_sdat_in,
        output i2c_sclk, i2c_sdat_oe, busy, done, error, entry_idx
    );

    modport slave (
        output start, i2c_sdat_in,
        input  i2c_sclk, i2c_sdat_oe, busy, done, error, entry_idx
    );
endinterface

`default_nettype wire

// File: rtl/wm8731_i2c_config.sv
// ============================================================================
// Module   : wm8731_i2c_config
// Purpose  : Boot-time WM8731 register loader: one 3-byte I2C write per table entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wm8731_i2c_config #(
    parameter int         CLK_FREQ_HZ = 28000000,
    parameter int         I2C_FREQ_HZ = 100000,
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         RETRY_MAX   = 3,
    parameter bit         AUTO_START  = 1'b1
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    wm8731_i2c_config_if.master  bus
);

    localparam int         c_QDIV_RAW   = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int         c_QDIV       = (c_QDIV_RAW < 1) ? 1 : c_QDIV_RAW;
    localparam int         c_TW         = $clog2(c_QDIV + 1);
    localparam int         c_RW         = $clog2(RETRY_MAX + 2);
    localparam logic [3:0] c_LAST_ENTRY = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BYTE  = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_GAP   = 3'd5,
        S_FIN   = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    // Register table word = {reg[6:0], data[8:0]}
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = {7'd15, 9'h000};
            4'd1:    table_word = {7'd0,  9'h017};
            4'd2:    table_word = {7'd1,  9'h017};
            4'd3:    table_word = {7'd2,  9'h079};
            4'd4:    table_word = {7'd3,  9'h079};
            4'd5:    table_word = {7'd4,  9'h012};
            4'd6:    table_word = {7'd5,  9'h000};
            4'd7:    table_word = {7'd6,  9'h000};
            4'd8:    table_word = {7'd7,  9'h002};
            default: table_word = {7'd9,  9'h001};
        endcase
    endfunction

    state_t            r_state, w_state;
    logic [c_TW-1:0]   r_tick;
    logic [1:0]        r_q, w_q;
    logic [2:0]        r_bit, w_bit_n;
    logic [1:0]        r_byte, w_byte_n;
    logic [3:0]        r_entry, w_entry;
    logic [c_RW-1:0]   r_retry, w_retry;
    logic              r_nack, w_nack;
    logic              r_auto, w_auto;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_error, w_error;
    logic              r_sclk, w_sclk;
    logic              r_oe, w_oe;
    logic              r_sda_in;
    logic              w_qtick;
    logic [15:0]       w_word;
    logic [7:0]        w_byte;
    logic              w_bit;

    assign w_qtick = (r_tick == c_TW'(c_QDIV - 1));
    assign w_word  = table_word(r_entry);
    assign w_byte  = (r_byte == 2'd0) ? {DEV_ADDR, 1'b0} :
                     (r_byte == 2'd1) ? w_word[15:8] : w_word[7:0];
    assign w_bit   = w_byte[r_bit];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick <= '0;
        end else if (w_qtick) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + c_TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_q      <= 2'd0;
            r_bit    <= 3'd7;
            r_byte   <= 2'd0;
            r_entry  <= 4'd0;
            r_retry  <= '0;
            r_nack   <= 1'b0;
            r_auto   <= AUTO_START;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_sclk   <= 1'b1;
            r_oe     <= 1'b0;
            r_sda_in <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_q      <= w_q;
            r_bit    <= w_bit_n;
            r_byte   <= w_byte_n;
            r_entry  <= w_entry;
            r_retry  <= w_retry;
            r_nack   <= w_nack;
            r_auto   <= w_auto;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_error  <= w_error;
            r_sclk   <= w_sclk;
            r_oe     <= w_oe;
            r_sda_in <= bus.i2c_sdat_in;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_q      = r_q;
        w_bit_n  = r_bit;
        w_byte_n = r_byte;
        w_entry  = r_entry;
        w_retry  = r_retry;
        w_nack   = r_nack;
        w_auto   = r_auto;
        w_busy   = r_busy;
        w_done   = r_done;
        w_error  = r_error;
        w_sclk   = 1'b1;
        w_oe     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_q = 2'd0;
                if (bus.start || r_auto) begin
                    w_state = S_START;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_error = 1'b0;
                    w_entry = 4'd0;
                    w_retry = '0;
                    w_nack  = 1'b0;
                    w_auto  = 1'b0;
                end
            end
            S_START: begin
                w_sclk = (r_q != 2'd3);
                w_oe   = (r_q != 2'd0);
                if (w_qtick) begin
                    w_q = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        w_state  = S_BYTE;
                        w_byte_n = 2'd0;
                        w_bit_n  = 3'd7;
                    end
                end
            end
            S_BYTE: begin
                w_sclk = (r_q == 2'd1) || (r_q == 2'd2);
                w_oe   = ~w_bit;
                if (w_qtick) begin
                    w_q = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        if (r_bit == 3'd0) begin
                            w_state = S_ACK;
                        end else begin
                            w_bit_n = r_bit - 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                w_sclk = (r_q == 2'd1) || (r_q == 2'd2);
                if (w_qtick) begin
                    w_q = r_q + 2'd1;
                    if (r_q == 2'd2) begin
                        w_nack = r_sda_in;
                    end
                    if (r_q == 2'd3) begin
                        if (r_nack || (r_byte == 2'd2)) begin
                            w_state = S_STOP;
                        end else begin
                            w_state  = S_BYTE;
                            w_byte_n = r_byte + 2'd1;
                            w_bit_n  = 3'd7;
                        end
                    end
                end
            end
            S_STOP: begin
                // SDA held low across the SCL rise, released at q3 for the stop edge
                w_sclk = (r_q != 2'd0);
                w_oe   = (r_q != 2'd3);
                if (w_qtick) begin
                    w_q = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        w_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_qtick) begin
                    w_q = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        if (r_nack) begin
                            if (r_retry == c_RW'(RETRY_MAX)) begin
                                w_state = S_ERR;
                                w_busy  = 1'b0;
                                w_error = 1'b1;
                            end else begin
                                w_state = S_START;
                                w_retry = r_retry + c_RW'(1);
                                w_nack  = 1'b0;
                            end
                        end else if (r_entry == c_LAST_ENTRY) begin
                            w_state = S_FIN;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                        end else begin
                            w_state = S_START;
                            w_entry = r_entry + 4'd1;
                            w_retry = '0;
                        end
                    end
                end
            end
            S_FIN: begin
                w_state = S_IDLE;
            end
            S_ERR: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.i2c_sclk    = r_sclk;
    assign bus.i2c_sdat_oe = r_oe;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.error       = r_error;
    assign bus.entry_idx   = r_entry;

endmodule

`default_nettype wire

// File: tb/tb_wm8731_i2c_config.sv
// ============================================================================
// Module   : tb_wm8731_i2c_config
// Purpose  : Bench for wm8731_i2c_config with an I2C slave/decoder and frame scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wm8731_i2c_config;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic slave_oe = 1'b0;

    wm8731_i2c_config_if bus();

    always #5 clk = ~clk;

    assign bus.i2c_sdat_in = ~(bus.i2c_sdat_oe | slave_oe);

    wm8731_i2c_config #(
        .CLK_FREQ_HZ (400000),
        .I2C_FREQ_HZ (100000),
        .DEV_ADDR    (7'h1A),
        .RETRY_MAX   (3),
        .AUTO_START  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] c_tab [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                16'h0812, 16'h0A00, 16'h0C00, 16'h0E02, 16'h1201};

    int n_cmp = 0, n_fail = 0;
    int m_cmp = 0, m_fail = 0;
    int cyc = 0;
    int test_id = 0;
    int mode = 0;
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model, bus decoder, protocol checker and frame scoreboard monitor
    logic        scl, sda, scl_p = 1'b1, sda_p = 1'b1;
    int          quiet = 2, run = 100;
    bit          in_frame = 0, ack_slot = 0, nacked_once = 0;
    int          nbits = 0, nbytes = 0, cur_frame = 0;
    int          frame_no = 0, starts = 0, stops = 0, seen_test = -1;
    logic [7:0]  shreg = 8'h00;
    logic [23:0] fbytes = 24'h0;
    logic [31:0] got, exp_f;
    bit          busy_p = 0, done_p = 0;
    int          t_busy = 0, t_done = 0;

    always @(negedge clk) begin
        scl = bus.i2c_sclk;
        sda = bus.i2c_sdat_in;
        if (seen_test != test_id) begin
            seen_test = test_id; frame_no = 0; starts = 0; stops = 0; nacked_once = 0;
        end
        if (bus.busy && !busy_p) t_busy = cyc;
        if (bus.done && !done_p) t_done = cyc;
        busy_p = bus.busy;
        done_p = bus.done;
        if (!rst_n || quiet > 0) begin
            if (!rst_n) quiet = 2; else quiet--;
            in_frame = 0; ack_slot = 0; nbits = 0; slave_oe = 1'b0; run = 100;
        end else begin
            m_cmp++;
            if (bus.busy && bus.done) begin
                m_fail++; $display("FAIL busy_done_both: busy=%b done=%b at cyc %0d", bus.busy, bus.done, cyc);
            end
            if (scl != scl_p) begin
                m_cmp++;
                if (run < 2) begin
                    m_fail++; $display("FAIL scl_period: level lasted %0d clk, need >= 2 (cyc %0d)", run, cyc);
                end
                run = 1;
            end else begin
                run++;
            end
            if (sda != sda_p && scl != scl_p) begin
                m_fail++; $display("FAIL sda_scl_same_cycle: sda %b->%b scl %b->%b at cyc %0d", sda_p, sda, scl_p, scl, cyc);
            end else if (sda != sda_p && scl && scl_p) begin
                m_cmp++;
                if (!sda) begin
                    if (in_frame) begin
                        m_fail++; $display("FAIL repeated_start: START inside frame at cyc %0d", cyc);
                    end
                    in_frame = 1; starts++; cur_frame = frame_no; frame_no++;
                    nbits = 0; nbytes = 0; fbytes = 24'h0; ack_slot = 0;
                end else begin
                    if (!in_frame) begin
                        m_fail++; $display("FAIL stray_stop: STOP outside frame at cyc %0d", cyc);
                    end
                    stops++; in_frame = 0; slave_oe = 1'b0;
                    got = {8'(nbytes), fbytes};
                    m_cmp++;
                    if (exp_q.size() == 0) begin
                        m_fail++; $display("FAIL frame: got unexpected %h, none expected", got);
                    end else begin
                        exp_f = exp_q.pop_front();
                        if (got !== exp_f) begin
                            m_fail++; $display("FAIL frame: got %h expected %h", got, exp_f);
                        end
                    end
                end
            end else if (in_frame && scl && !scl_p) begin
                if (!ack_slot) begin
                    shreg = {shreg[6:0], sda};
                    nbits++;
                end
            end else if (in_frame && !scl && scl_p) begin
                if (ack_slot) begin
                    ack_slot = 0; slave_oe = 1'b0; nbits = 0;
                end else if (nbits == 8) begin
                    ack_slot = 1;
                    fbytes = {fbytes[15:0], shreg};
                    if (mode == 2) begin
                        slave_oe = 1'b0;
                    end else if (mode == 1 && cur_frame == 3 && nbytes == 0 && !nacked_once) begin
                        nacked_once = 1; slave_oe = 1'b0;
                    end else begin
                        slave_oe = 1'b1;
                    end
                    nbytes++;
                end
            end
        end
        scl_p = scl;
        sda_p = sda;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_fail++; $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
        end
    endtask

    task automatic chk_range(input string name, input int got_v, input int lo, input int hi);
        n_cmp++;
        if (got_v < lo || got_v > hi) begin
            n_fail++; $display("FAIL %s: got %0d expected %0d..%0d", name, got_v, lo, hi);
        end
    endtask

    task automatic push_full(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back({8'd3, 8'h34, c_tab[i]});
    endtask

    task automatic wait_end(input string name, input int budget);
        int k = 0;
        while (!(bus.done || bus.error) && k < budget) begin
            tick(1); k++;
        end
        n_cmp++;
        if (k >= budget) begin
            n_fail++; $display("FAIL %s_timeout: no done/error within %0d clk", name, budget);
        end
        tick(2);
    endtask

    task automatic wait_busy(input string name);
        int k = 0;
        while (!bus.busy && k < 50) begin
            tick(1); k++;
        end
        n_cmp++;
        if (k >= 50) begin
            n_fail++; $display("FAIL %s_busy_timeout: busy never rose", name);
        end
        tick(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;

        // 1: clean auto-start run
        test_id = 1; mode = 0; rst_n = 1'b0;
        tick(3);
        chk("rst_sclk",  32'(bus.i2c_sclk), 32'd1);
        chk("rst_oe",    32'(bus.i2c_sdat_oe), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_entry", 32'(bus.entry_idx), 32'd0);
        push_full(0, 9);
        rst_n = 1'b1;
        wait_end("t1", 3000);
        chk_range("t1_latency", t_done - t_busy, 1198, 1202);
        chk("t1_done",  32'(bus.done), 32'd1);
        chk("t1_error", 32'(bus.error), 32'd0);
        chk("t1_busy",  32'(bus.busy), 32'd0);
        tick(20);
        chk("t1_frames_left", 32'(exp_q.size()), 32'd0);

        // 2: single NACK on entry 3 address byte
        test_id = 2; mode = 1; rst_n = 1'b0;
        push_full(0, 2);
        exp_q.push_back({8'd1, 16'h0000, 8'h34});
        push_full(3, 9);
        tick(2);
        rst_n = 1'b1;
        wait_end("t2", 3000);
        chk("t2_done",  32'(bus.done), 32'd1);
        chk("t2_error", 32'(bus.error), 32'd0);
        chk("t2_frames_left", 32'(exp_q.size()), 32'd0);

        // 3: NACK everything, retries exhausted on entry 0
        test_id = 3; mode = 2; rst_n = 1'b0;
        repeat (4) exp_q.push_back({8'd1, 16'h0000, 8'h34});
        tick(2);
        rst_n = 1'b1;
        wait_end("t3", 3000);
        chk("t3_error", 32'(bus.error), 32'd1);
        chk("t3_done",  32'(bus.done), 32'd0);
        chk("t3_entry", 32'(bus.entry_idx), 32'd0);
        chk("t3_busy",  32'(bus.busy), 32'd0);
        tick(20);
        chk("t3_starts", 32'(starts), 32'd4);
        chk("t3_stops",  32'(stops), 32'd4);
        chk("t3_frames_left", 32'(exp_q.size()), 32'd0);

        // 4: starts while busy and on the done cycle are ignored; later start reruns
        test_id = 4; mode = 0; rst_n = 1'b0;
        push_full(0, 9);
        tick(2);
        rst_n = 1'b1;
        wait_busy("t4");
        while (cyc < t_busy + 400) tick(1);
        bus.start = 1'b1; tick(1); bus.start = 1'b0;
        while (cyc < t_busy + 1199) tick(1);
        bus.start = 1'b1; tick(1); bus.start = 1'b0;
        tick(2);
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        tick(300);
        chk("t4_idle_busy", 32'(bus.busy), 32'd0);
        chk("t4_frames_left", 32'(exp_q.size()), 32'd0);
        push_full(0, 9);
        bus.start = 1'b1; tick(1); bus.start = 1'b0;
        chk("t4_rerun_busy", 32'(bus.busy), 32'd1);
        chk("t4_rerun_done_cleared", 32'(bus.done), 32'd0);
        tick(1);
        wait_end("t4_rerun", 3000);
        chk_range("t4_rerun_latency", t_done - t_busy, 1198, 1202);
        chk("t4_rerun_done", 32'(bus.done), 32'd1);
        chk("t4_rerun_frames_left", 32'(exp_q.size()), 32'd0);

        // 5: one-clock reset during the second byte of entry 5
        test_id = 5; mode = 0; rst_n = 1'b0;
        push_full(0, 4);
        tick(2);
        rst_n = 1'b1;
        wait_busy("t5");
        while (cyc < t_busy + 655) tick(1);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        chk("t5_sclk", 32'(bus.i2c_sclk), 32'd1);
        chk("t5_oe",   32'(bus.i2c_sdat_oe), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_frames_before_reset", 32'(exp_q.size()), 32'd0);
        push_full(0, 9);
        wait_end("t5", 3000);
        chk("t5_done",  32'(bus.done), 32'd1);
        chk("t5_error", 32'(bus.error), 32'd0);
        tick(20);
        chk("t5_frames_left", 32'(exp_q.size()), 32'd0);

        n_cmp  += m_cmp;
        n_fail += m_fail;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
